// File: rtl/deserializer.sv
// deserializer: gathers NUM_WORDS consecutive WIDTH-bit words into one frame.
// A frame is published with a one-cycle o_dv strobe. A partial frame whose
// i_dv gap runs past GAP_MAX is dropped and reported on o_err. Dropped
// frames are also counted in a saturating counter.
module deserializer #(
  parameter int WIDTH         = 8,
  parameter int NUM_WORDS     = 4,
  parameter bit LITTLE_ENDIAN = 1,
  parameter int GAP_MAX       = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_dv,
  output logic [NUM_WORDS*WIDTH-1:0]   o_data,
  output logic                         o_dv,
  output logic                         o_err,
  output logic                         o_busy,
  output logic [ERR_CNT_WIDTH-1:0]     o_err_cnt
);

  localparam int TW = NUM_WORDS * WIDTH;
  localparam int PW = (NUM_WORDS - 1) * WIDTH;  // words held before the last one arrives
  localparam int IW = $clog2(NUM_WORDS);
  localparam int GW = $clog2(GAP_MAX + 2);
  localparam logic [IW-1:0] LAST    = IW'(NUM_WORDS - 1);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_MAX);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap;
  logic [PW-1:0] sreg, sreg_nxt;
  logic [TW-1:0] frame_nxt;
  logic          last, gap_hit;
  logic          capture, done, abort;

  assign last    = (idx == LAST);
  assign gap_hit = (gap == GAP_LIM);
  assign o_busy  = (idx != '0);

  // Word placement: the frame is the held words plus the word on the bus now.
  // Holding only NUM_WORDS-1 words keeps every shift-register bit in use.
  generate
    if (LITTLE_ENDIAN) begin : g_le
      assign frame_nxt = {i_data, sreg};
      if (NUM_WORDS > 2) begin : g_sh
        assign sreg_nxt = {i_data, sreg[PW-1:WIDTH]};
      end else begin : g_one
        assign sreg_nxt = i_data;
      end
    end else begin : g_be
      assign frame_nxt = {sreg, i_data};
      if (NUM_WORDS > 2) begin : g_sh
        assign sreg_nxt = {sreg[PW-WIDTH-1:0], i_data};
      end else begin : g_one
        assign sreg_nxt = i_data;
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_dv) state_nxt = COLLECT;
      COLLECT: begin
        if (i_dv && last)          state_nxt = IDLE;
        else if (!i_dv && gap_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control outputs: capture a word, finish a frame, or abort a partial one
  always_comb begin
    capture = i_dv;
    done    = 1'b0;
    abort   = 1'b0;
    if (state == COLLECT) begin
      done  = i_dv && last;
      abort = !i_dv && gap_hit;
    end
  end

  // Word index and gap counter
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      idx <= '0;
      gap <= '0;
    end else begin
      if (capture)    idx <= done ? '0 : idx + 1'b1;
      else if (abort) idx <= '0;
      if (state == COLLECT && !i_dv) gap <= abort ? '0 : gap + 1'b1;
      else                           gap <= '0;
    end
  end

  // Shift register loads only on valid words, so X on idle data stays out
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)      sreg <= '0;
    else if (capture) sreg <= sreg_nxt;
    else if (abort)   sreg <= '0;
  end

  // Published frame, strobes and saturating abort counter
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_data    <= '0;
      o_dv      <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (done) o_data <= frame_nxt;
      o_dv  <= done;
      o_err <= abort;
      if (abort && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed tests for three deserializer builds.
// The builds are LE with no gap allowed, BE with no gap allowed, and LE
// with GAP_MAX=2.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = '0;
  logic        dv_a = 1'b0;   // drives the LE and BE builds together
  logic        dv_g = 1'b0;   // drives the GAP_MAX=2 build

  logic [31:0] le_data, be_data, g2_data;
  logic        le_dv, le_err, le_busy, be_dv, be_err, be_busy, g2_dv, g2_err, g2_busy;
  logic [7:0]  le_cnt, be_cnt, g2_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  deserializer #(.LITTLE_ENDIAN(1), .GAP_MAX(0)) u_le (
    .clk(clk), .i_reset(rst), .i_data(data), .i_dv(dv_a),
    .o_data(le_data), .o_dv(le_dv), .o_err(le_err), .o_busy(le_busy), .o_err_cnt(le_cnt));

  deserializer #(.LITTLE_ENDIAN(0), .GAP_MAX(0)) u_be (
    .clk(clk), .i_reset(rst), .i_data(data), .i_dv(dv_a),
    .o_data(be_data), .o_dv(be_dv), .o_err(be_err), .o_busy(be_busy), .o_err_cnt(be_cnt));

  deserializer #(.LITTLE_ENDIAN(1), .GAP_MAX(2)) u_g2 (
    .clk(clk), .i_reset(rst), .i_data(data), .i_dv(dv_g),
    .o_data(g2_data), .o_dv(g2_dv), .o_err(g2_err), .o_busy(g2_busy), .o_err_cnt(g2_cnt));

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({le_data, le_dv, le_err, le_busy, le_cnt} !== 43'h0) begin
      errors++; $display("FAIL reset_le got=%h exp=0", {le_data, le_dv, le_err, le_busy, le_cnt});
    end
    checks++;
    if ({g2_data, g2_dv, g2_err, g2_busy, g2_cnt} !== 43'h0) begin
      errors++; $display("FAIL reset_g2 got=%h exp=0", {g2_data, g2_dv, g2_err, g2_busy, g2_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  // Frame 11,22,33,44 into the LE and BE builds
  task automatic test_endian();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      dv_a = 1'b1; data = w[i];
      step();
      checks++;
      if (le_busy !== (i < 3) || le_dv !== (i == 3) || le_err !== 1'b0) begin
        errors++; $display("FAIL le_word%0d busy/dv/err got=%b%b%b exp=%b%b0", i, le_busy, le_dv, le_err, i < 3, i == 3);
      end
    end
    checks++;
    if (le_data !== 32'h44332211) begin
      errors++; $display("FAIL le_frame got=%h exp=44332211", le_data);
    end
    checks++;
    if (be_data !== 32'h11223344 || be_dv !== 1'b1) begin
      errors++; $display("FAIL be_frame got=%h dv=%b exp=11223344 dv=1", be_data, be_dv);
    end
    dv_a = 1'b0; data = 'x;
    step();
    checks++;
    if (le_dv !== 1'b0 || le_data !== 32'h44332211 || be_dv !== 1'b0) begin
      errors++; $display("FAIL dv_one_cycle got le_dv=%b le_data=%h be_dv=%b exp 0 44332211 0", le_dv, le_data, be_dv);
    end
  endtask

  // Continuous i_dv for 8 words: strobes on the 4th and 8th edges
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      dv_a = 1'b1; data = 8'(i + 1);
      step();
      checks++;
      if (le_dv !== (i == 3 || i == 7)) begin
        errors++; $display("FAIL b2b_dv%0d got=%b exp=%b", i, le_dv, (i == 3 || i == 7));
      end
      if (i == 3) begin
        checks++;
        if (le_data !== 32'h04030201) begin
          errors++; $display("FAIL b2b_frame0 got=%h exp=04030201", le_data);
        end
      end
    end
    checks++;
    if (le_data !== 32'h08070605) begin
      errors++; $display("FAIL b2b_frame1 got=%h exp=08070605", le_data);
    end
    dv_a = 1'b0; data = 'x;
    step();
  endtask

  // GAP_MAX=0: AA,BB then one idle cycle aborts; next full frame lands
  task automatic test_abort_nogap();
    dv_a = 1'b1; data = 8'hAA; step();
    data = 8'hBB; step();
    dv_a = 1'b0; data = 'x; step();
    checks++;
    if (le_err !== 1'b1 || le_cnt !== 8'd1 || le_busy !== 1'b0 || le_dv !== 1'b0) begin
      errors++; $display("FAIL nogap_abort got err=%b cnt=%0d busy=%b dv=%b exp 1 1 0 0", le_err, le_cnt, le_busy, le_dv);
    end
    checks++;
    if (le_data !== 32'h08070605) begin
      errors++; $display("FAIL nogap_hold got=%h exp=08070605", le_data);
    end
    for (int i = 0; i < 4; i++) begin
      dv_a = 1'b1; data = 8'(i + 1);
      step();
      checks++;
      if (le_err !== 1'b0 || (i < 3 && le_data !== 32'h08070605)) begin
        errors++; $display("FAIL nogap_refill%0d got err=%b data=%h", i, le_err, le_data);
      end
    end
    checks++;
    if (le_data !== 32'h04030201 || le_dv !== 1'b1 || le_cnt !== 8'd1) begin
      errors++; $display("FAIL nogap_frame got=%h dv=%b cnt=%0d exp=04030201 1 1", le_data, le_dv, le_cnt);
    end
    dv_a = 1'b0; data = 'x; step();
  endtask

  // GAP_MAX=2: 2-cycle gap tolerated, 3-cycle gap aborts, counter saturates
  task automatic test_gap_tolerance();
    logic [7:0] w [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      dv_g = 1'b1; data = w[i]; step();
      if (i == 1) begin
        dv_g = 1'b0; data = 'x;
        for (int g = 0; g < 2; g++) begin
          step();
          checks++;
          if (g2_err !== 1'b0 || g2_busy !== 1'b1) begin
            errors++; $display("FAIL gap2_low%0d got err=%b busy=%b exp 0 1", g, g2_err, g2_busy);
          end
        end
      end
    end
    checks++;
    if (g2_data !== 32'h04030201 || g2_dv !== 1'b1 || g2_cnt !== 8'd0) begin
      errors++; $display("FAIL gap2_frame got=%h dv=%b cnt=%0d exp=04030201 1 0", g2_data, g2_dv, g2_cnt);
    end
    dv_g = 1'b1; data = 8'h05; step();
    data = 8'h06; step();
    dv_g = 1'b0; data = 'x;
    for (int g = 0; g < 3; g++) begin
      step();
      checks++;
      if (g2_err !== (g == 2) || g2_dv !== 1'b0) begin
        errors++; $display("FAIL gap3_low%0d got err=%b dv=%b exp=%b 0", g, g2_err, g2_dv, g == 2);
      end
    end
    checks++;
    if (g2_cnt !== 8'd1 || g2_data !== 32'h04030201) begin
      errors++; $display("FAIL gap3_cnt got cnt=%0d data=%h exp 1 04030201", g2_cnt, g2_data);
    end
    for (int n = 0; n < 299; n++) begin
      dv_g = 1'b1; data = 8'h5A; step();
      dv_g = 1'b0; data = 'x;
      repeat (3) step();
      if (n == 253) begin
        checks++;
        if (g2_cnt !== 8'd255) begin
          errors++; $display("FAIL sat_reach got=%0d exp=255", g2_cnt);
        end
      end
    end
    checks++;
    if (g2_cnt !== 8'd255 || g2_err !== 1'b1) begin
      errors++; $display("FAIL sat_hold got cnt=%0d err=%b exp 255 1", g2_cnt, g2_err);
    end
  endtask

  // Async reset between edges mid-frame, then a DEADBEEF word stream
  task automatic test_async_reset_loopback();
    dv_a = 1'b1; data = 8'h11; step();
    data = 8'h22; step();
    dv_a = 1'b0; data = 'x;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (le_busy !== 1'b0 || le_data !== 32'h0 || le_cnt !== 8'd0 || g2_cnt !== 8'd0 || le_err !== 1'b0) begin
      errors++; $display("FAIL async_clear got busy=%b data=%h cnt=%0d g2cnt=%0d err=%b", le_busy, le_data, le_cnt, g2_cnt, le_err);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (le_err !== 1'b0 || le_busy !== 1'b0) begin
      errors++; $display("FAIL async_no_err got err=%b busy=%b exp 0 0", le_err, le_busy);
    end
    begin
      logic [7:0] w [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 4; i++) begin
        dv_a = 1'b1; data = w[i]; step();
      end
    end
    checks++;
    if (le_data !== 32'hDEADBEEF || le_dv !== 1'b1) begin
      errors++; $display("FAIL loopback got=%h dv=%b exp=deadbeef 1", le_data, le_dv);
    end
    dv_a = 1'b0; data = 'x; step();
    checks++;
    if (le_dv !== 1'b0 || le_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL loopback_pulse got dv=%b data=%h exp 0 deadbeef", le_dv, le_data);
    end
  endtask

  initial begin
    test_reset();
    test_endian();
    test_back_to_back();
    test_abort_nogap();
    test_gap_tolerance();
    test_async_reset_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
